lab_access_arbiter: RTL and testbench
=====================================

Name: lab_access_arbiter

Overview:
- Shares the two lab occupancy counters (Mera, Digital) among NUM_READERS door card readers.
- Accepts one reader request at a time under round-robin arbitration and evaluates enter/exit rules: capacity, the parity restriction above the free limit, and exit from an empty lab.
- Commits the count update and returns a grant/deny response to the winning reader.
- Sits between the per-door reader front-ends and the lab status displays.

Parameters:
- NUM_READERS, 4, number of requesting readers; 2..8.
- CAPACITY, 30, maximum students per lab.
- FREE_LIMIT, 15, occupancy below which entry needs no parity check.
- CNT_W, 6, count width; must satisfy 2^CNT_W > CAPACITY.
- IDX_W, 2, reader index width; must equal clog2(NUM_READERS).

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- req_valid  in  NUM_READERS  per-reader request valid.
- req_ready  out  NUM_READERS  per-reader accept strobe.
- req_lab  in  NUM_READERS  per-reader lab select; 0 = Digital, 1 = Mera.
- req_enter  in  NUM_READERS  per-reader direction; 1 = enter, 0 = exit.
- req_code  in  5*NUM_READERS  per-reader smart code; reader k uses bits [5k+4:5k].
- resp_valid  out  1  response strobe, one cycle.
- resp_reader  out  IDX_W  index of the reader being answered.
- resp_grant  out  1  1 = door unlocks.
- resp_reason  out  2  00 OK, 01 FULL, 10 RESTRICTED, 11 EMPTY.
- numMera  out  CNT_W  Mera occupancy.
- numDigital  out  CNT_W  Digital occupancy.
- fullMera, emptyMera, fullDigital, emptyDigital  out  1 each  status flags.

Behaviour:
- Reset (async, RSTN=0):
  - state=IDLE; counts 0; emptyMera=emptyDigital=1; fullMera=fullDigital=0.
  - resp_valid=0, resp_grant=0, resp_reason=00, resp_reader=0, req_ready=0.
  - RR pointer = NUM_READERS-1, so reader 0 has first priority.
- FSM has three states: IDLE -> EVAL -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, the winner is the first valid reader scanning upward (with wrap) from pointer+1.
  - req_ready[winner]=1 combinationally in this cycle only. The transfer occurs when valid and ready are both high.
  - Capture the winner's index, lab, enter and code; set pointer=winner; go to EVAL.
  - If no request is valid, stay in IDLE with req_ready all 0.
- Readers hold valid and data stable until ready. A reader's valid may drop without being served; it is then skipped.
- EVAL (one cycle). Let n be the selected lab's count and p = XOR of the 5 code bits.
  - Enter, n==CAPACITY: deny, FULL.
  - Enter, n<FREE_LIMIT: grant, n+1.
  - Enter, otherwise: Mera grants iff p==0 (even ones); Digital grants iff p==1. Grant gives n+1. Deny gives RESTRICTED.
  - Exit, n==0: deny, EMPTY.
  - Exit, otherwise: grant, n-1.
  - Count and flags update at the end of EVAL. full = (n==CAPACITY), empty = (n==0), recomputed from the new value.
  - The other lab is untouched.
- RESP (one cycle): resp_valid=1 with registered resp_reader, resp_grant and resp_reason.
- Response fields hold their last values after RESP; only resp_valid returns to 0.
- Latency and throughput:
  - Accept in cycle t gives resp_valid in cycle t+2, with counts already updated.
  - Peak rate is one request per 3 cycles.
- Counts never leave 0..CAPACITY. No wrap-around is possible.
- Fairness: with all readers permanently valid, the grant order is 0,1,2,3,0,…
- Reset asserted mid-transaction: the transaction is dropped, no response is issued, and everything returns to reset values.

Decomposition:
- Shared package lab_pkg holds:
  - reason codes REASON_OK, REASON_FULL, REASON_RESTRICTED, REASON_EMPTY;
  - lab select constants LAB_DIGITAL=0, LAB_MERA=1;
  - FSM state encoding;
  - default CAPACITY and FREE_LIMIT.
- One sub-module, rr_arbiter (parameter N), implements the round-robin logic:
  - inputs: request vector, pointer;
  - outputs: one-hot grant, grant index, any-valid flag.
- Counter and flag logic stays in the top module, as two identical per-lab instances of the same always block.

Test Plan:
- Reset, then reader 0 requests enter Mera, code 00000. Ready in cycle 1; resp_valid in cycle 3 with reader 0, grant 1, OK; numMera=1, emptyMera=0.
- Readers 0–3 all hold valid entering Digital. Service order is 0,1,2,3,0; numDigital increments by 1 per response (1,2,3,4,5).
- Preload Mera to 15, then enter with code 00001 → deny, RESTRICTED, numMera stays 15. Then code 00011 → grant, numMera=16.
- Preload Digital to 29, enter with code 00001 → grant, numDigital=30, fullDigital=1. Next enter → deny, FULL. Then exit → grant, 29, fullDigital=0.
- Exit Mera while empty → deny, EMPTY; numMera=0 and emptyMera=1 unchanged.
- Accept a request, then pulse RSTN low during EVAL → no resp_valid, counts 0, and the next request is served from reader 0 priority.

Source files
------------

// File: rtl/lab_pkg.sv
// Shared definitions for the lab access arbiter: reason codes, lab selects,
// FSM encoding and default occupancy limits.
package lab_pkg;

  // Response reason codes
  localparam logic [1:0] REASON_OK         = 2'b00;
  localparam logic [1:0] REASON_FULL       = 2'b01;
  localparam logic [1:0] REASON_RESTRICTED = 2'b10;
  localparam logic [1:0] REASON_EMPTY      = 2'b11;

  // Lab select values carried on req_lab
  localparam logic LAB_DIGITAL = 1'b0;
  localparam logic LAB_MERA    = 1'b1;

  // Default occupancy limits
  localparam int unsigned DEFAULT_CAPACITY   = 30;
  localparam int unsigned DEFAULT_FREE_LIMIT = 15;

  // Arbiter FSM: accept, evaluate, respond
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEval = 2'd1,
    StResp = 2'd2
  } labState_t;

  // Parity of a 5-bit smart code (1 = odd number of ones)
  function automatic logic codeParity(input logic [4:0] code);
    return ^code;
  endfunction

endpackage

// File: rtl/lab_access_arbiter_if.sv
// Reader-side request/response bundle of the lab access arbiter.
interface lab_access_arbiter_if #(
  parameter int unsigned NUM_READERS = 4,
  parameter int unsigned IDX_W       = 2
);

  logic [NUM_READERS-1:0]   req_valid;
  logic [NUM_READERS-1:0]   req_ready;
  logic [NUM_READERS-1:0]   req_lab;
  logic [NUM_READERS-1:0]   req_enter;
  logic [5*NUM_READERS-1:0] req_code;
  logic                     resp_valid;
  logic [IDX_W-1:0]         resp_reader;
  logic                     resp_grant;
  logic [1:0]               resp_reason;

  // Reader front-ends
  modport master (
    output req_valid, req_lab, req_enter, req_code,
    input  req_ready, resp_valid, resp_reader, resp_grant, resp_reason
  );

  // Arbiter
  modport slave (
    input  req_valid, req_lab, req_enter, req_code,
    output req_ready, resp_valid, resp_reader, resp_grant, resp_reason
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request scanning upward (with wrap)
// from the slot after ptr.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gntIdx,
  output logic          anyValid
);

  logic [IW-1:0] cand;

  // Scan ptr+1 .. ptr+N modulo N and keep the first requester found
  always_comb begin
    gnt      = '0;
    gntIdx   = '0;
    anyValid = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!anyValid && req[cand]) begin
        anyValid  = 1'b1;
        gnt[cand] = 1'b1;
        gntIdx    = cand;
      end
    end
  end

endmodule

// File: rtl/lab_access_arbiter.sv
// Shares the Mera and Digital occupancy counters among the door readers.
// One request is accepted at a time, evaluated against capacity / parity /
// empty rules, committed, and answered two cycles after acceptance.
module lab_access_arbiter
  import lab_pkg::*;
#(
  parameter int unsigned NUM_READERS = 4,
  parameter int unsigned CAPACITY    = DEFAULT_CAPACITY,
  parameter int unsigned FREE_LIMIT  = DEFAULT_FREE_LIMIT,
  parameter int unsigned CNT_W       = 6,
  parameter int unsigned IDX_W       = 2
) (
  input  logic             CLK,
  input  logic             RSTN,
  lab_access_arbiter_if.slave bus,
  output logic [CNT_W-1:0] numMera,
  output logic [CNT_W-1:0] numDigital,
  output logic             fullMera,
  output logic             emptyMera,
  output logic             fullDigital,
  output logic             emptyDigital
);

  localparam logic [CNT_W-1:0] CapCnt  = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] FreeCnt = CNT_W'(FREE_LIMIT);

  labState_t stateQ, stateD;

  logic [IDX_W-1:0]       ptrQ;
  logic [IDX_W-1:0]       selIdxQ;
  logic                   selLabQ;
  logic                   selEnterQ;
  logic [4:0]             selCodeQ;
  logic [IDX_W-1:0]       respReaderQ;
  logic                   respGrantQ;
  logic [1:0]             respReasonQ;
  logic [CNT_W-1:0]       meraQ;
  logic [CNT_W-1:0]       digitalQ;

  logic [NUM_READERS-1:0] arbGnt;
  logic [IDX_W-1:0]       arbIdx;
  logic                   arbAny;
  logic                   accept;
  logic                   winLab;
  logic                   winEnter;
  logic [4:0]             winCode;
  logic [CNT_W-1:0]       selCnt;
  logic                   evalGrant;
  logic [1:0]             evalReason;
  logic                   wantParity;

  rr_arbiter #(
    .N  (NUM_READERS),
    .IW (IDX_W)
  ) uArb (
    .req      (bus.req_valid),
    .ptr      (ptrQ),
    .gnt      (arbGnt),
    .gntIdx   (arbIdx),
    .anyValid (arbAny)
  );

  assign accept = (stateQ == StIdle) && arbAny;

  // Mux the winning reader's request fields
  always_comb begin
    winLab   = 1'b0;
    winEnter = 1'b0;
    winCode  = '0;
    for (int k = 0; k < int'(NUM_READERS); k++) begin
      if (arbGnt[k]) begin
        winLab   = bus.req_lab[k];
        winEnter = bus.req_enter[k];
        winCode  = bus.req_code[5*k +: 5];
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) stateQ <= StIdle;
    else       stateQ <= stateD;
  end

  // FSM next state
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (arbAny) stateD = StEval;
      StEval:  stateD = StResp;
      StResp:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // FSM outputs: ready only to the winner while idle, response strobe in RESP
  always_comb begin
    bus.req_ready  = '0;
    bus.resp_valid = 1'b0;
    if (stateQ == StIdle) bus.req_ready  = arbGnt;
    if (stateQ == StResp) bus.resp_valid = 1'b1;
  end

  // Capture the accepted request and advance the round-robin pointer
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptrQ      <= IDX_W'(NUM_READERS - 1);
      selIdxQ   <= '0;
      selLabQ   <= LAB_DIGITAL;
      selEnterQ <= 1'b0;
      selCodeQ  <= '0;
    end else if (accept) begin
      ptrQ      <= arbIdx;
      selIdxQ   <= arbIdx;
      selLabQ   <= winLab;
      selEnterQ <= winEnter;
      selCodeQ  <= winCode;
    end
  end

  assign selCnt = (selLabQ == LAB_MERA) ? meraQ : digitalQ;
  // Above the free limit Mera admits even codes and Digital admits odd codes
  assign wantParity = (selLabQ == LAB_DIGITAL);

  // Entry / exit rule evaluation on the selected lab
  always_comb begin
    evalGrant  = 1'b0;
    evalReason = REASON_OK;
    if (selEnterQ) begin
      if (selCnt == CapCnt) begin
        evalReason = REASON_FULL;
      end else if (selCnt < FreeCnt) begin
        evalGrant = 1'b1;
      end else if (codeParity(selCodeQ) == wantParity) begin
        evalGrant = 1'b1;
      end else begin
        evalReason = REASON_RESTRICTED;
      end
    end else begin
      if (selCnt == '0) evalReason = REASON_EMPTY;
      else              evalGrant  = 1'b1;
    end
  end

  // Register the response at the end of EVAL; fields hold afterwards
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      respReaderQ <= '0;
      respGrantQ  <= 1'b0;
      respReasonQ <= REASON_OK;
    end else if (stateQ == StEval) begin
      respReaderQ <= selIdxQ;
      respGrantQ  <= evalGrant;
      respReasonQ <= evalReason;
    end
  end

  assign bus.resp_reader = respReaderQ;
  assign bus.resp_grant  = respGrantQ;
  assign bus.resp_reason = respReasonQ;

  // Mera occupancy update on a granted Mera request
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      meraQ <= '0;
    end else if ((stateQ == StEval) && evalGrant && (selLabQ == LAB_MERA)) begin
      meraQ <= selEnterQ ? meraQ + 1'b1 : meraQ - 1'b1;
    end
  end

  // Digital occupancy update on a granted Digital request
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      digitalQ <= '0;
    end else if ((stateQ == StEval) && evalGrant && (selLabQ == LAB_DIGITAL)) begin
      digitalQ <= selEnterQ ? digitalQ + 1'b1 : digitalQ - 1'b1;
    end
  end

  assign numMera      = meraQ;
  assign numDigital   = digitalQ;
  assign fullMera     = (meraQ == CapCnt);
  assign emptyMera    = (meraQ == '0);
  assign fullDigital  = (digitalQ == CapCnt);
  assign emptyDigital = (digitalQ == '0);

endmodule

// File: tb/tb_lab_access_arbiter.sv
// Self-checking bench for lab_access_arbiter: vector table of requests with
// expected responses, scoreboard queue filled on acceptance and drained on
// resp_valid, plus hand sequences for fairness, hold and mid-transaction reset.
module tb_lab_access_arbiter;
  import lab_pkg::*;

  localparam int NR = 4;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic [5:0] numMera, numDigital;
  logic       fullMera, emptyMera, fullDigital, emptyDigital;

  always #5 CLK = ~CLK;

  lab_access_arbiter_if #(.NUM_READERS(NR), .IDX_W(2)) bus ();

  lab_access_arbiter #(
    .NUM_READERS (NR),
    .CAPACITY    (30),
    .FREE_LIMIT  (15),
    .CNT_W       (6),
    .IDX_W       (2)
  ) dut (
    .CLK          (CLK),
    .RSTN         (RSTN),
    .bus          (bus),
    .numMera      (numMera),
    .numDigital   (numDigital),
    .fullMera     (fullMera),
    .emptyMera    (emptyMera),
    .fullDigital  (fullDigital),
    .emptyDigital (emptyDigital)
  );

  typedef struct {
    int         reader;
    bit         lab;
    bit         enter;
    logic [4:0] code;
    bit         expGrant;
    logic [1:0] expReason;
    int         expMera;
    int         expDigital;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   nChecks = 0;
  int   nErrors = 0;

  function automatic vec_t mk(input int rd, input bit lab, input bit enter,
                              input logic [4:0] code, input bit g, input logic [1:0] r,
                              input int m, input int d);
    vec_t v;
    v.reader = rd; v.lab = lab; v.enter = enter; v.code = code;
    v.expGrant = g; v.expReason = r; v.expMera = m; v.expDigital = d;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nErrors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input int rd, input bit lab, input bit enter, input logic [4:0] code);
    bus.req_lab[rd]          = lab;
    bus.req_enter[rd]        = enter;
    bus.req_code[5*rd +: 5]  = code;
    bus.req_valid[rd]        = 1'b1;
  endtask

  // Wait for an accept, check the one-hot ready, push the expected response
  task automatic waitAccept(input logic [NR-1:0] expReady, input vec_t exp);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (|bus.req_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("accept_seen", int'(got), 1);
    if (got) begin
      chk("req_ready", int'(bus.req_ready), int'(expReady));
      sb.push_back(exp);
    end
    @(posedge CLK);
    #1;
  endtask

  // Wait for resp_valid and compare against the oldest scoreboard entry
  task automatic waitResp(input int expLat);
    bit   got = 1'b0;
    int   n   = 0;
    vec_t e;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      n++;
      if (bus.resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("resp_seen", int'(got), 1);
    if (got) begin
      chk("resp_latency", n, expLat);
      if (sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk("resp_reader", int'(bus.resp_reader), e.reader);
        chk("resp_grant", int'(bus.resp_grant), int'(e.expGrant));
        chk("resp_reason", int'(bus.resp_reason), int'(e.expReason));
        chk("numMera", int'(numMera), e.expMera);
        chk("numDigital", int'(numDigital), e.expDigital);
        chk("fullMera", int'(fullMera), int'(e.expMera == 30));
        chk("emptyMera", int'(emptyMera), int'(e.expMera == 0));
        chk("fullDigital", int'(fullDigital), int'(e.expDigital == 30));
        chk("emptyDigital", int'(emptyDigital), int'(e.expDigital == 0));
      end
    end
  endtask

  task automatic doReset();
    RSTN          = 1'b0;
    bus.req_valid = '0;
    bus.req_lab   = '0;
    bus.req_enter = '0;
    bus.req_code  = '0;
    sb.delete();
    repeat (2) @(negedge CLK);
    chk("rst_numMera", int'(numMera), 0);
    chk("rst_numDigital", int'(numDigital), 0);
    chk("rst_emptyMera", int'(emptyMera), 1);
    chk("rst_emptyDigital", int'(emptyDigital), 1);
    chk("rst_fullMera", int'(fullMera), 0);
    chk("rst_fullDigital", int'(fullDigital), 0);
    chk("rst_resp_valid", int'(bus.resp_valid), 0);
    chk("rst_resp_grant", int'(bus.resp_grant), 0);
    chk("rst_resp_reason", int'(bus.resp_reason), 0);
    chk("rst_resp_reader", int'(bus.resp_reader), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    RSTN = 1'b1;
  endtask

  // Serve one table entry with only its reader valid
  task automatic runVec(input vec_t v);
    @(posedge CLK);
    #1;
    drive(v.reader, v.lab, v.enter, v.code);
    waitAccept(NR'(1 << v.reader), v);
    bus.req_valid[v.reader] = 1'b0;
    waitResp(2);
  endtask

  initial begin
    // Single Mera entry straight after reset, then response field hold
    doReset();
    runVec(mk(0, LAB_MERA, 1'b1, 5'b00000, 1'b1, REASON_OK, 1, 0));
    @(negedge CLK);
    chk("hold_resp_valid", int'(bus.resp_valid), 0);
    chk("hold_resp_grant", int'(bus.resp_grant), 1);
    chk("hold_numMera", int'(numMera), 1);

    // Fairness: all readers valid entering Digital
    doReset();
    @(posedge CLK);
    #1;
    for (int r = 0; r < NR; r++) drive(r, LAB_DIGITAL, 1'b1, 5'b00001);
    for (int k = 0; k < 5; k++) begin
      waitAccept(NR'(1 << (k % NR)),
                 mk(k % NR, LAB_DIGITAL, 1'b1, 5'b00001, 1'b1, REASON_OK, 0, k + 1));
      if (k == 4) bus.req_valid = '0;
      waitResp(2);
    end

    // Boundary table: parity restriction, capacity, empty exit
    doReset();
    for (int i = 0; i < 15; i++)
      vecs.push_back(mk(i % NR, LAB_MERA, 1'b1, 5'b00000, 1'b1, REASON_OK, i + 1, 0));
    vecs.push_back(mk(1, LAB_MERA, 1'b1, 5'b00001, 1'b0, REASON_RESTRICTED, 15, 0));
    vecs.push_back(mk(2, LAB_MERA, 1'b1, 5'b00011, 1'b1, REASON_OK, 16, 0));
    vecs.push_back(mk(0, LAB_MERA, 1'b1, 5'b11100, 1'b0, REASON_RESTRICTED, 16, 0));
    for (int i = 0; i < 29; i++) begin
      vecs.push_back(mk(i % NR, LAB_DIGITAL, 1'b1, 5'b00001, 1'b1, REASON_OK, 16, i + 1));
      if (i == 19)
        vecs.push_back(mk(3, LAB_DIGITAL, 1'b1, 5'b00110, 1'b0, REASON_RESTRICTED, 16, 20));
    end
    vecs.push_back(mk(0, LAB_DIGITAL, 1'b1, 5'b10000, 1'b1, REASON_OK, 16, 30));
    vecs.push_back(mk(1, LAB_DIGITAL, 1'b1, 5'b00001, 1'b0, REASON_FULL, 16, 30));
    vecs.push_back(mk(2, LAB_DIGITAL, 1'b0, 5'b00000, 1'b1, REASON_OK, 16, 29));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(i % NR, LAB_MERA, 1'b0, 5'b00000, 1'b1, REASON_OK, 15 - i, 29));
    vecs.push_back(mk(3, LAB_MERA, 1'b0, 5'b00000, 1'b0, REASON_EMPTY, 0, 29));
    foreach (vecs[i]) runVec(vecs[i]);

    // Reset during EVAL drops the transaction and restores reader-0 priority
    doReset();
    @(posedge CLK);
    #1;
    drive(2, LAB_MERA, 1'b1, 5'b00000);
    waitAccept(NR'(4), mk(2, LAB_MERA, 1'b1, 5'b00000, 1'b1, REASON_OK, 1, 0));
    bus.req_valid = '0;
    RSTN = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("midrst_resp_valid", int'(bus.resp_valid), 0);
    end
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("midrst_no_resp", int'(bus.resp_valid), 0);
    end
    chk("midrst_numMera", int'(numMera), 0);
    @(posedge CLK);
    #1;
    for (int r = 0; r < NR; r++) drive(r, LAB_MERA, 1'b1, 5'b00000);
    waitAccept(NR'(1), mk(0, LAB_MERA, 1'b1, 5'b00000, 1'b1, REASON_OK, 1, 0));
    bus.req_valid = '0;
    waitResp(2);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
